// File: rtl/rapids_pkg.sv
// Shared fetch-path types: word geometry, the queued fetch entry and the fetch state encoding.
package rapids_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // One prefetched instruction; a fault entry carries word 0.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] word;
        logic              fault;
    } fetch_entry_t;

    // RUN fetches sequentially, HALT parks after a faulting fetch until redirected.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-controlpath handshake: valid/ready with the head instruction, its pc and fault flag.
interface instr_fetch_if;
    import rapids_pkg::*;

    logic              fetch_valid;
    logic [WORD_W-1:0] fetch_instr;
    logic [WORD_W-1:0] fetch_pc;
    logic              fetch_fault;
    logic              fetch_ready;

    // Producer side (the fetch unit).
    modport master (
        output fetch_valid,
        output fetch_instr,
        output fetch_pc,
        output fetch_fault,
        input  fetch_ready
    );

    // Consumer side (the controlpath).
    modport slave (
        input  fetch_valid,
        input  fetch_instr,
        input  fetch_pc,
        input  fetch_fault,
        output fetch_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO, first-word-fall-through, with flush.
// A push into a full queue is accepted when a pop happens in the same cycle.
module fetch_fifo import rapids_pkg::*; #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         valid,
    output logic         full
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rptr_q;
    logic [AW-1:0] wptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // Pop needs a head entry; push into a full queue only alongside a pop.
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    assign valid = (count_q != '0);
    assign full  = (count_q == DEPTH_CNT);
    assign rdata = mem_q[rptr_q];

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    // Entry storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks the fetch address, captures MMU words into the prefetch queue,
// parks after a faulting fetch and restarts on redirect.
module instr_fetch import rapids_pkg::*; #(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [WORD_W-1:0] instr_addr,
    input  logic [WORD_W-1:0] instr,
    input  logic              wait_instr,
    input  logic              instr_segv,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    instr_fetch_if.master     fetch_bus
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [WORD_W-1:0] fetch_pc_q;
    logic [WORD_W-1:0] fetch_pc_d;
    logic              q_valid;
    logic              q_full;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Redirect blocks both sides of the queue; the flush wins that cycle.
    assign pop  = q_valid && fetch_bus.fetch_ready && !redirect;
    assign push = (state_q == RUN) && !wait_instr && !redirect && (!q_full || pop);

    // Faulting fetches are queued as markers with a zero word.
    always_comb begin
        push_entry       = '0;
        push_entry.pc    = fetch_pc_q;
        push_entry.word  = instr_segv ? '0 : instr;
        push_entry.fault = instr_segv;
    end

    // Next fetch address and state: redirect restarts, a fault parks, a normal push advances.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            state_d    = RUN;
        end else if (push) begin
            if (instr_segv) begin
                state_d = HALT;
            end else begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end
        end
    end

    // Fetch address and state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            state_q    <= RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            state_q    <= state_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .valid (q_valid),
        .full  (q_full)
    );

    assign instr_addr            = fetch_pc_q;
    assign fetch_bus.fetch_valid = q_valid;
    assign fetch_bus.fetch_instr = head.word;
    assign fetch_bus.fetch_pc    = head.pc;
    assign fetch_bus.fetch_fault = head.fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: phase table plus hand sequences, checked against a queue-based model.
module tb_instr_fetch;
    import rapids_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int unsigned DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        wait_instr;
    logic        instr_segv;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        segv_en;
    logic [31:0] segv_addr;

    instr_fetch_if fbus ();

    instr_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_addr  (instr_addr),
        .instr       (instr),
        .wait_instr  (wait_instr),
        .instr_segv  (instr_segv),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_bus   (fbus.master)
    );

    always #5 clk = ~clk;

    // MMU model: word is address xor a fixed pattern, optional fault at one address.
    assign instr      = instr_addr ^ 32'hA5A5_A5A5;
    assign instr_segv = segv_en && (instr_addr == segv_addr);

    typedef struct {
        bit          rst;
        bit          redir;
        logic [31:0] rpc;
        bit          wt;
        bit          rnd;
        bit          ready;
        bit          segv_en;
        logic [31:0] segv_addr;
        int          cycles;
        bit          chk_end;
        bit          exp_valid;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t         vecs[$];
    fetch_entry_t sb[$];
    logic [31:0]  m_pc;
    bit           m_halt;
    bit           rnd_mode;
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare at negedge against the model, advance the model, then take the edge.
    task automatic tick();
        bit           mv;
        bit           mpop;
        bit           mpush;
        bit           mseg;
        fetch_entry_t e;
        if (rnd_mode) begin
            wait_instr      = 1'($urandom_range(0, 1));
            fbus.fetch_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        mv = (sb.size() != 0);
        check("fetch_valid", {31'b0, fbus.fetch_valid}, {31'b0, mv});
        check("instr_addr", instr_addr, m_pc);
        if (mv && fbus.fetch_valid) begin
            check("head_pc", fbus.fetch_pc, sb[0].pc);
            check("head_instr", fbus.fetch_instr, sb[0].word);
            check("head_fault", {31'b0, fbus.fetch_fault}, {31'b0, sb[0].fault});
        end
        if (rst) begin
            sb.delete();
            m_pc   = RST_PC;
            m_halt = 1'b0;
        end else if (redirect) begin
            sb.delete();
            m_pc   = redirect_pc;
            m_halt = 1'b0;
        end else begin
            mpop  = mv && (fbus.fetch_ready == 1'b1);
            mpush = !m_halt && (wait_instr == 1'b0) && ((sb.size() < DEPTH) || mpop);
            if (mpop) begin
                void'(sb.pop_front());
            end
            if (mpush) begin
                mseg    = (segv_en == 1'b1) && (m_pc == segv_addr);
                e.pc    = m_pc;
                e.word  = mseg ? 32'h0 : (m_pc ^ 32'hA5A5_A5A5);
                e.fault = mseg;
                sb.push_back(e);
                if (mseg) begin
                    m_halt = 1'b1;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_end(input string name, input bit exp_valid, input logic [31:0] exp_addr);
        check({name, "_valid"}, {31'b0, fbus.fetch_valid}, {31'b0, exp_valid});
        check({name, "_addr"}, instr_addr, exp_addr);
    endtask

    initial begin
        rst              = 1'b1;
        redirect         = 1'b0;
        redirect_pc      = 32'h0;
        wait_instr       = 1'b0;
        segv_en          = 1'b0;
        segv_addr        = 32'h0;
        rnd_mode         = 1'b0;
        fbus.fetch_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_pc   = RST_PC;
        m_halt = 1'b0;

        //            rst   redir rpc           wt    rnd   ready segv  saddr  cyc end   valid addr
        vecs.push_back('{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1,  1'b1, 1'b0, 32'hFFFF_FFF8});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1,  1'b1, 1'b1, 32'hFFFF_FFFC});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2,  1'b1, 1'b1, 32'h4});
        vecs.push_back('{1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1,  1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 3,  1'b1, 1'b1, 32'hC});
        vecs.push_back('{1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1,  1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10, 1'b1, 1'b1, 32'h10});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6,  1'b1, 1'b1, 32'h28});
        vecs.push_back('{1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 1,  1'b1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 3,  1'b1, 1'b1, 32'h8});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 20, 1'b1, 1'b0, 32'h8});
        vecs.push_back('{1'b0, 1'b1, 32'h100,    1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 1,  1'b1, 1'b0, 32'h100});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2,  1'b1, 1'b1, 32'h108});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5,  1'b1, 1'b1, 32'h114});
        vecs.push_back('{1'b0, 1'b1, 32'h40,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1,  1'b1, 1'b0, 32'h40});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1,  1'b1, 1'b1, 32'h44});
        vecs.push_back('{1'b0, 1'b1, RST_PC,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1,  1'b1, 1'b0, RST_PC});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 40, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h200,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1,  1'b1, 1'b0, 32'h200});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 3,  1'b1, 1'b1, 32'h20C});
        vecs.push_back('{1'b1, 1'b1, 32'h40,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1,  1'b1, 1'b0, RST_PC});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1,  1'b1, 1'b1, 32'hFFFF_FFFC});
        vecs.push_back('{1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 3,  1'b1, 1'b0, 32'hFFFF_FFFC});

        foreach (vecs[i]) begin
            rst              = vecs[i].rst;
            redirect         = vecs[i].redir;
            redirect_pc      = vecs[i].rpc;
            wait_instr       = vecs[i].wt;
            rnd_mode         = vecs[i].rnd;
            fbus.fetch_ready = vecs[i].ready;
            segv_en          = vecs[i].segv_en;
            segv_addr        = vecs[i].segv_addr;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                tick();
            end
            if (vecs[i].chk_end) begin
                check_end($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_addr);
            end
        end

        // A fault presented while the MMU stalls must be ignored.
        rst              = 1'b0;
        rnd_mode         = 1'b0;
        redirect         = 1'b1;
        redirect_pc      = 32'h300;
        wait_instr       = 1'b0;
        fbus.fetch_ready = 1'b1;
        segv_en          = 1'b0;
        tick();
        redirect   = 1'b0;
        segv_en    = 1'b1;
        segv_addr  = 32'h300;
        wait_instr = 1'b1;
        tick();
        tick();
        check_end("stall_segv", 1'b0, 32'h300);
        segv_en    = 1'b0;
        wait_instr = 1'b0;
        tick();
        check_end("stall_release", 1'b1, 32'h304);

        // Fault captured into a full queue alongside a pop, then the queue drains while parked.
        redirect         = 1'b1;
        redirect_pc      = 32'h400;
        fbus.fetch_ready = 1'b0;
        tick();
        redirect = 1'b0;
        repeat (4) tick();
        check_end("fill", 1'b1, 32'h410);
        segv_en          = 1'b1;
        segv_addr        = 32'h410;
        fbus.fetch_ready = 1'b1;
        tick();
        check_end("full_fault", 1'b1, 32'h410);
        repeat (3) tick();
        check_end("fault_head", 1'b1, 32'h410);
        check("fault_head_flag", {31'b0, fbus.fetch_fault}, 32'h1);
        check("fault_head_word", fbus.fetch_instr, 32'h0);
        tick();
        check_end("parked_empty", 1'b0, 32'h410);
        repeat (5) tick();
        check_end("parked_hold", 1'b0, 32'h410);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries; power of two and at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address loaded on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr_addr  output  32  fetch address to MMU; driven directly from the fetch_pc register.
REQ-006 instr  input  32  MMU instruction word for instr_addr; valid in the same cycle when wait_instr=0.
REQ-007 wait_instr  input  1  MMU not ready; the current word must not be captured.
REQ-008 instr_segv  input  1  instr_addr faulted; qualified by wait_instr=0.
REQ-009 redirect  input  1  load a new fetch address and flush the queue.
REQ-010 redirect_pc  input  32  target address for redirect.
REQ-011 fetch_valid  output  1  queue head holds an entry (count != 0).
REQ-012 fetch_instr  output  32  head instruction word (first-word-fall-through).
REQ-013 fetch_pc  output  32  address of the head instruction.
REQ-014 fetch_fault  output  1  head entry is a segv marker; fetch_instr=0 for such entries.
REQ-015 fetch_ready  input  1  consumer (controlpath) accepts the head when fetch_valid=1.

Function
REQ-016 SHALL use two states: RUN (fetching) and HALT (stopped after a fault).
REQ-017 push condition: state=RUN, wait_instr=0, redirect=0, and (count<DEPTH or a pop occurs this cycle).
REQ-018 on push SHALL enqueue {instr_addr, instr, instr_segv} and advance instr_addr by 4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 0).
REQ-019 pushed entry with instr_segv=1 SHALL be stored with fault=1 and word 0; instr_addr SHALL hold its value; state SHALL go to HALT.
REQ-020 in HALT: SHALL issue no pushes and hold instr_addr; queued entries still drain normally.
REQ-021 pop SHALL occur when fetch_valid=1 and fetch_ready=1 and redirect=0; it removes the head at the clock edge.
REQ-022 simultaneous push and pop SHALL leave count unchanged, including when count=DEPTH.
REQ-023 redirect=1 SHALL, at the edge:
  - set count=0;
  - set instr_addr=redirect_pc;
  - set state=RUN.
  It takes priority over push, pop, and segv in that cycle.
REQ-024 latency: a word captured at edge N SHALL appear at the head after edge N if the queue was empty; no bubble beyond that single edge.
REQ-025 wait_instr=1 SHALL stall capture only; instr_addr stays stable and queued entries remain poppable.
REQ-026 fetch_instr, fetch_pc, and fetch_fault SHALL be don't-care when fetch_valid=0; benches SHALL check them only while fetch_valid=1.
REQ-027 count SHALL never exceed DEPTH or underflow; pop on empty SHALL be impossible by construction.

Reset
REQ-028 rst=1 at an edge SHALL set:
  - instr_addr=RESET_PC;
  - count=0, read/write pointers=0;
  - state=RUN;
  - fetch_valid=0.
REQ-029 rst SHALL override redirect, push, and pop in the same cycle.
REQ-030 rst asserted mid-stream SHALL discard all queued entries; the first post-reset push SHALL be from RESET_PC.
REQ-031 queue storage contents SHALL not require reset.

Structure
REQ-032 shared package rapids_pkg SHALL hold:
  - WORD_W=32;
  - INSTR_BYTES=4;
  - a fetch-entry struct {pc, word, fault};
  - the state enum {RUN, HALT}.
REQ-033 the queue SHALL be the sub-module fetch_fifo: DEPTH-entry synchronous FIFO with flush, first-word-fall-through, simultaneous push/pop when full.
REQ-034 instr_fetch SHALL contain only the fetch_pc register, the state machine, and push/pop/flush control.

Verification
REQ-035 reset, fetch_ready=1, wait_instr=0, MMU returns addr^32'hA5A5_A5A5 -> entries at pc 0,4,8,... one per cycle; first fetch_valid one edge after reset release.
REQ-036 fetch_ready=0 for 10 cycles -> exactly 4 entries (pc 0..12), instr_addr held at 16; then ready=1 -> drain in order with no gap or duplicate.
REQ-037 instr_segv=1 at addr 8 -> entries 0, 4, then 8 with fault=1 and word 0; no further pushes for 20 cycles; redirect to 0x100 -> entries resume from 0x100.
REQ-038 redirect_pc=0x40 with a full queue, push, and pop all in one cycle -> next cycle fetch_valid=0, instr_addr=0x40; next entry pc=0x40.
REQ-039 RESET_PC=32'hFFFF_FFF8 -> entry pcs FFFF_FFF8, FFFF_FFFC, 0000_0000; wait_instr toggled randomly -> no lost or duplicated entry.
REQ-040 rst asserted with 3 entries queued and redirect=1 -> fetch_valid=0 next cycle, first entry pc=RESET_PC.
